// File: rtl/redun_mont_pkg.sv
// Shared parameters and types for the redundant Montgomery squarer and its
// redundant-to-binary output stage.
package redun_mont_pkg;

  localparam int WRD_BITS = 16;
  localparam int NUM_WRDS = 4;
  localparam int CNT_W    = (NUM_WRDS > 1) ? $clog2(NUM_WRDS) : 1;

  // Modulus; must fit in NUM_WRDS*WRD_BITS bits.
  localparam logic [NUM_WRDS*WRD_BITS-1:0] P =
    (NUM_WRDS*WRD_BITS)'(64'h1234_5678_9ABC_DEF1);

  // One redundant word: WRD_BITS data bits plus one carry bit.
  typedef logic [WRD_BITS:0] redun0_t;

  typedef logic [NUM_WRDS-1:0][WRD_BITS-1:0] bin_wrds_t;

  localparam bin_wrds_t P_WRDS = P;

  typedef enum logic [1:0] {
    IDLE,
    CARRY,
    SUB,
    DONE
  } redun_to_bin_state_t;

endpackage

// File: rtl/redun_word_addsub.sv
// One-word combinational slice: mode=0 adds a+b+cin (2-bit carry out),
// mode=1 subtracts a-b-cin (borrow out in cout[0]).
module redun_word_addsub
  import redun_mont_pkg::*;
(
  input  logic [WRD_BITS:0]   a,
  input  logic [WRD_BITS-1:0] b,
  input  logic [1:0]          cin,
  input  logic                mode,
  output logic [WRD_BITS-1:0] res,
  output logic [1:0]          cout
);

  logic [WRD_BITS+1:0] sum;

  always_comb begin
    sum  = '0;
    cout = '0;
    if (mode) begin
      // Operands are below 2^WRD_BITS here, so a negative result sets the top bit.
      sum  = {1'b0, a} - {2'b00, b} - {{WRD_BITS{1'b0}}, cin};
      cout = {1'b0, sum[WRD_BITS+1]};
    end else begin
      sum  = {1'b0, a} + {2'b00, b} + {{WRD_BITS{1'b0}}, cin};
      cout = sum[WRD_BITS+1:WRD_BITS];
    end
    res = sum[WRD_BITS-1:0];
  end

endmodule

// File: rtl/redun_to_bin.sv
// Word-serial carry resolution of one redundant result into binary.
// Optional final reduction into [0,P) enabled by defining REDUN_FINAL_REDUCE_EN.
module redun_to_bin
  import redun_mont_pkg::*;
#(
  parameter int MAX_SUB = 4
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [NUM_WRDS-1:0][WRD_BITS:0]  i_mul,
  input  logic                             i_val,
  output logic                             o_rdy,
  output logic [NUM_WRDS*WRD_BITS-1:0]     o_bin,
  output logic                             o_val,
  output logic                             o_overflow,
  output logic                             o_drop
);

  localparam int OUT_BITS = NUM_WRDS*WRD_BITS;

  if (MAX_SUB < 1) begin : g_bad_max_sub
    $error("redun_to_bin: MAX_SUB must be at least 1");
  end

  redun_to_bin_state_t state_q, state_d;

  redun0_t [NUM_WRDS-1:0] word_buf_q;
  bin_wrds_t              out_q;
  logic [OUT_BITS-1:0]    hold_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [1:0]             carry_q;
  logic                   ovf_q;
  logic                   drop_q;
  logic                   last_wrd;

  logic [WRD_BITS:0]      sl_a;
  logic [WRD_BITS-1:0]    sl_b;
  logic [1:0]             sl_cin;
  logic                   sl_mode;
  logic [WRD_BITS-1:0]    sl_res;
  logic [1:0]             sl_cout;

`ifdef REDUN_FINAL_REDUCE_EN
  localparam int NSUB_W = $clog2(MAX_SUB + 1);

  bin_wrds_t              trial_q;
  bin_wrds_t              trial_nxt;
  logic                   borrow_q;
  logic [NSUB_W-1:0]      nsub_q;
`endif

  assign last_wrd = (cnt_q == CNT_W'(NUM_WRDS - 1));

  always_comb begin
    sl_a    = word_buf_q[cnt_q];
    sl_b    = '0;
    sl_cin  = carry_q;
    sl_mode = 1'b0;
`ifdef REDUN_FINAL_REDUCE_EN
    if (state_q == SUB) begin
      sl_a    = {1'b0, out_q[cnt_q]};
      sl_b    = P_WRDS[cnt_q];
      sl_cin  = {1'b0, borrow_q};
      sl_mode = 1'b1;
    end
`endif
  end

  redun_word_addsub u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (sl_cin),
    .mode (sl_mode),
    .res  (sl_res),
    .cout (sl_cout)
  );

`ifdef REDUN_FINAL_REDUCE_EN
  always_comb begin
    trial_nxt        = trial_q;
    trial_nxt[cnt_q] = sl_res;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (i_val) state_d = CARRY;
      CARRY: if (last_wrd) begin
`ifdef REDUN_FINAL_REDUCE_EN
        state_d = SUB;
`else
        state_d = DONE;
`endif
      end
`ifdef REDUN_FINAL_REDUCE_EN
      // Stop on a failed trial, or once MAX_SUB trials have been committed.
      SUB: if (last_wrd && (sl_cout[0] || (nsub_q == NSUB_W'(MAX_SUB - 1))))
        state_d = DONE;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    o_rdy      = (state_q == IDLE);
    o_val      = (state_q == DONE);
    o_bin      = o_val ? out_q : hold_q;
    o_overflow = o_val & ovf_q;
    o_drop     = drop_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      word_buf_q <= '0;
      out_q      <= '0;
      hold_q     <= '0;
      cnt_q      <= '0;
      carry_q    <= '0;
      ovf_q      <= 1'b0;
      drop_q     <= 1'b0;
`ifdef REDUN_FINAL_REDUCE_EN
      trial_q    <= '0;
      borrow_q   <= 1'b0;
      nsub_q     <= '0;
`endif
    end else begin
      drop_q <= i_val && (state_q != IDLE);
      case (state_q)
        IDLE: if (i_val) begin
          word_buf_q <= i_mul;
          cnt_q      <= '0;
          carry_q    <= '0;
          ovf_q      <= 1'b0;
        end
        CARRY: begin
          out_q[cnt_q] <= sl_res;
          carry_q      <= sl_cout;
          cnt_q        <= last_wrd ? '0 : cnt_q + 1'b1;
          if (last_wrd) begin
            ovf_q    <= (sl_cout != 2'd0);
`ifdef REDUN_FINAL_REDUCE_EN
            borrow_q <= 1'b0;
            nsub_q   <= '0;
`endif
          end
        end
`ifdef REDUN_FINAL_REDUCE_EN
        SUB: begin
          trial_q  <= trial_nxt;
          borrow_q <= sl_cout[0];
          cnt_q    <= last_wrd ? '0 : cnt_q + 1'b1;
          if (last_wrd) begin
            borrow_q <= 1'b0;
            if (!sl_cout[0]) begin
              out_q  <= trial_nxt;
              nsub_q <= nsub_q + 1'b1;
              if (nsub_q == NSUB_W'(MAX_SUB - 1)) ovf_q <= 1'b1;
            end
          end
        end
`endif
        DONE:    hold_q <= out_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_redun_to_bin.sv
// Directed self-checking bench for redun_to_bin; reduce-specific vectors are
// compiled in when REDUN_FINAL_REDUCE_EN is defined.
module tb_redun_to_bin;
  import redun_mont_pkg::*;

  localparam int N = NUM_WRDS;
  localparam int W = WRD_BITS;
  localparam int MAXS = 2;
`ifdef REDUN_FINAL_REDUCE_EN
  localparam int LAT0 = 2*N + 1;
`else
  localparam int LAT0 = N + 1;
`endif

  typedef logic [N-1:0][W:0] redun_vec_t;

  logic              i_clk;
  logic              i_rst;
  redun_vec_t        i_mul;
  logic              i_val;
  logic              o_rdy;
  logic [N*W-1:0]    o_bin;
  logic              o_val;
  logic              o_overflow;
  logic              o_drop;

  int total = 0;
  int bad   = 0;

  redun_to_bin #(.MAX_SUB(MAXS)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_mul      (i_mul),
    .i_val      (i_val),
    .o_rdy      (o_rdy),
    .o_bin      (o_bin),
    .o_val      (o_val),
    .o_overflow (o_overflow),
    .o_drop     (o_drop)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic redun_vec_t to_redun(input logic [N*W-1:0] v);
    redun_vec_t r;
    for (int i = 0; i < N; i++) r[i] = {1'b0, v[i*W +: W]};
    return r;
  endfunction

  function automatic redun_vec_t fill(input logic [W:0] w);
    redun_vec_t r;
    for (int i = 0; i < N; i++) r[i] = w;
    return r;
  endfunction

  // Launch one operand and wait (bounded) for o_val; lat counts cycles from i_val.
  task automatic run_op(input redun_vec_t v, output logic [N*W-1:0] bin,
                        output logic ovf, output int lat);
    @(negedge i_clk);
    i_mul = v;
    i_val = 1'b1;
    @(negedge i_clk);
    i_val = 1'b0;
    lat   = 1;
    while (!o_val && lat < 200) begin
      @(negedge i_clk);
      lat++;
    end
    bin = o_bin;
    ovf = o_overflow;
  endtask

  initial begin
    logic [N*W-1:0] bin;
    logic           ovf;
    int             lat;
    int             nval;
    redun_vec_t     v;

    i_rst = 1'b1;
    i_val = 1'b0;
    i_mul = '0;
    repeat (3) @(negedge i_clk);
    chk("rst_rdy",  64'(o_rdy), 64'd1);
    chk("rst_val",  64'(o_val), 64'd0);
    chk("rst_ovf",  64'(o_overflow), 64'd0);
    chk("rst_drop", 64'(o_drop), 64'd0);
    chk("rst_bin",  64'(o_bin), 64'd0);
    i_rst = 1'b0;

    run_op('0, bin, ovf, lat);
    chk("zero_bin", 64'(bin), 64'd0);
    chk("zero_ovf", 64'(ovf), 64'd0);
    chk("zero_lat", 64'(lat), 64'(LAT0));
    @(negedge i_clk);
    chk("val_pulse", 64'(o_val), 64'd0);

    v = '0;
    for (int i = 0; i < N-1; i++) v[i] = {1'b1, {W{1'b0}}};
    run_op(v, bin, ovf, lat);
    chk("cbit_bin", 64'(bin), 64'h0001_0001_0001_0000);
    chk("cbit_ovf", 64'(ovf), 64'd0);
    chk("cbit_lat", 64'(lat), 64'(LAT0));

    run_op(fill({(W+1){1'b1}}), bin, ovf, lat);
    chk("ones_bin", 64'(bin), 64'h0001_0001_0000_FFFF);
    chk("ones_ovf", 64'(ovf), 64'd1);

    v[0] = 17'h1_2345; v[1] = 17'h0_FFFF; v[2] = 17'h1_8000; v[3] = 17'h0_0001;
    run_op(v, bin, ovf, lat);
    chk("mix_bin", 64'(bin), 64'h0002_8001_0000_2345);
    chk("mix_ovf", 64'(ovf), 64'd0);

`ifdef REDUN_FINAL_REDUCE_EN
    run_op(to_redun(P + 64'd5), bin, ovf, lat);
    chk("p5_bin", 64'(bin), 64'd5);
    chk("p5_ovf", 64'(ovf), 64'd0);
    chk("p5_lat", 64'(lat), 64'(N + 1 + N*2));

    run_op(to_redun(P - 64'd1), bin, ovf, lat);
    chk("pm1_bin", 64'(bin), 64'(P - 64'd1));
    chk("pm1_lat", 64'(lat), 64'(N + 1 + N));

    run_op(to_redun(3*P + 64'd2), bin, ovf, lat);
    chk("p3_bin", 64'(bin), 64'(P + 64'd2));
    chk("p3_ovf", 64'(ovf), 64'd1);
    chk("p3_lat", 64'(lat), 64'(N + 1 + N*MAXS));
`endif

    // Second i_val two cycles into an operation.
    @(negedge i_clk);
    i_mul = v;
    i_val = 1'b1;
    @(negedge i_clk);
    i_val = 1'b0;
    lat   = 1;
    @(negedge i_clk);
    i_mul = fill(17'h1_5555);
    i_val = 1'b1;
    lat++;
    @(negedge i_clk);
    i_val = 1'b0;
    lat++;
    chk("busy_drop", 64'(o_drop), 64'd1);
    chk("busy_rdy",  64'(o_rdy), 64'd0);
    while (!o_val && lat < 200) begin
      @(negedge i_clk);
      lat++;
    end
    chk("busy_bin", 64'(o_bin), 64'h0002_8001_0000_2345);
    chk("busy_lat", 64'(lat), 64'(LAT0));

    // i_val coinciding with o_val is dropped, not started.
    i_mul = fill(17'h0_1111);
    i_val = 1'b1;
    @(negedge i_clk);
    i_val = 1'b0;
    chk("done_drop", 64'(o_drop), 64'd1);
    chk("done_rdy",  64'(o_rdy), 64'd1);
    @(negedge i_clk);
    chk("done_nodrop", 64'(o_drop), 64'd0);

    // Reset mid-CARRY aborts the operand.
    @(negedge i_clk);
    i_mul = fill({(W+1){1'b1}});
    i_val = 1'b1;
    @(negedge i_clk);
    i_val = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("abort_rdy", 64'(o_rdy), 64'd1);
    nval = 0;
    for (int i = 0; i < 3*N; i++) begin
      @(negedge i_clk);
      if (o_val) nval++;
    end
    chk("abort_noval", 64'(nval), 64'd0);

    run_op(to_redun(64'h0BAD_F00D_1234_5678), bin, ovf, lat);
    chk("after_bin", 64'(bin), 64'h0BAD_F00D_1234_5678);
    chk("after_lat", 64'(lat), 64'(LAT0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
